// File: rtl/imem_boot_arbiter.sv
// Boot loader / fetch arbiter for the imem port. It assembles a little-endian image
// from the UART byte stream, writes it into imem, and then hands the port to fetch.
module imem_boot_arbiter #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [31:0]           fetch_raddr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr1,
  output logic                  imem_we,
  output logic [31:0]           imem_wdata,
  output logic                  core_rstn,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic [ADDR_WIDTH:0]   loaded_words
);

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_RUN, S_ERR} state_t;

  localparam logic [32:0]         CAP   = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE_W = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  state_t                state, state_nx;
  logic [1:0]            byte_cnt;
  logic [31:0]           shreg;
  logic [ADDR_WIDTH:0]   word_cnt, n_words;
  logic                  we_r, done_r, err_r, crst_r;
  logic [31:0]           wdata_r;
  logic                  accept, word_done;
  logic [31:0]           word_in;
  logic                  unused_raddr;

  // Bytes are consumed only while the loader owns the port.
  assign accept    = rx_valid && (state == S_HDR || state == S_LOAD);
  assign word_done = accept && (byte_cnt == 2'd3);
  assign word_in   = {rx_data, shreg[31:8]};

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR: begin
        if (word_done) begin
          if (word_in == 32'd0)               state_nx = S_RUN;
          else if ({1'b0, word_in} > CAP)     state_nx = S_ERR;
          else                                state_nx = S_LOAD;
        end
      end
      // Leave only once the final write pulse is on the port.
      S_LOAD:  if (we_r && (word_cnt == n_words - ONE_W)) state_nx = S_RUN;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_HDR;
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
      word_cnt <= '0;
      n_words  <= '0;
      we_r     <= 1'b0;
      wdata_r  <= 32'd0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      crst_r   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shreg    <= word_in;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_HDR && word_done) n_words <= word_in[ADDR_WIDTH:0];
      we_r <= (state == S_LOAD) && word_done;
      if (state == S_LOAD && word_done) wdata_r <= word_in;
      if (we_r) word_cnt <= word_cnt + ONE_W;
      if (state_nx == S_RUN) begin
        done_r <= 1'b1;
        crst_r <= 1'b1;
      end
      if (state_nx == S_ERR) err_r <= 1'b1;
    end
  end

  // Fetch address path is purely combinational once the core runs.
  assign imem_addr    = (state == S_RUN) ? fetch_raddr[ADDR_WIDTH+1:2] : word_cnt[ADDR_WIDTH-1:0];
  assign imem_addr1   = imem_addr + ONE_A;
  assign imem_we      = we_r;
  assign imem_wdata   = wdata_r;
  assign core_rstn    = crst_r;
  assign boot_done    = done_r;
  assign boot_err     = err_r;
  assign loaded_words = word_cnt;
  assign unused_raddr = ^{fetch_raddr[31:ADDR_WIDTH+2], fetch_raddr[1:0]};

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter: two instances (ADDR_WIDTH 15 and 4), each
// with a write scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_imem_boot_arbiter;

  logic        clk = 1'b0;
  logic        rstn15, rstn4;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] fetch_raddr;

  logic [14:0] addr15, addr1_15;
  logic        we15, crst15, done15, err15;
  logic [31:0] wdata15;
  logic [15:0] lw15;
  logic [3:0]  addr4, addr1_4;
  logic        we4, crst4, done4, err4;
  logic [31:0] wdata4;
  logic [4:0]  lw4;

  int tests = 0, fails = 0;
  logic [63:0] q15[$], q4[$];
  logic pwe15 = 1'b0, pwe4 = 1'b0;
  logic [31:0] words5[5];

  always #5 clk = ~clk;

  imem_boot_arbiter #(.ADDR_WIDTH(15)) dut15 (
    .clk(clk), .rstn(rstn15), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetch_raddr(fetch_raddr), .imem_addr(addr15), .imem_addr1(addr1_15),
    .imem_we(we15), .imem_wdata(wdata15), .core_rstn(crst15),
    .boot_done(done15), .boot_err(err15), .loaded_words(lw15));

  imem_boot_arbiter #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn4), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetch_raddr(fetch_raddr), .imem_addr(addr4), .imem_addr1(addr1_4),
    .imem_we(we4), .imem_wdata(wdata4), .core_rstn(crst4),
    .boot_done(done4), .boot_err(err4), .loaded_words(lw4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (we15) begin
      if (q15.size() == 0) chk("unexpected_wr15", 64'(addr15), 64'hFFFF_FFFF);
      else chk("wr15", {32'(addr15), wdata15}, q15.pop_front());
      if (pwe15) chk("we_back_to_back15", 1, 0);
    end
    if (we4) begin
      if (q4.size() == 0) chk("unexpected_wr4", 64'(addr4), 64'hFFFF_FFFF);
      else chk("wr4", {32'(addr4), wdata4}, q4.pop_front());
      if (pwe4) chk("we_back_to_back4", 1, 0);
    end
    pwe15 = we15;
    pwe4  = we4;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic reset15();
    rstn15 = 1'b0; step();
    chk("rst15_we", 64'(we15), 0);
    chk("rst15_core_rstn", 64'(crst15), 0);
    chk("rst15_done", 64'(done15), 0);
    chk("rst15_err", 64'(err15), 0);
    chk("rst15_loaded", 64'(lw15), 0);
    rstn15 = 1'b1;
  endtask

  task automatic reset4();
    rstn4 = 1'b0; step();
    chk("rst4_loaded", 64'(lw4), 0);
    chk("rst4_done", 64'(done4), 0);
    rstn4 = 1'b1;
  endtask

  initial begin
    rstn15 = 1'b0; rstn4 = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fetch_raddr = 32'h0;
    step();

    // 1: two-word image
    reset15();
    send_word(32'd2, 0);
    q15.push_back({32'd0, 32'h0000_0013});
    send_word(32'h0000_0013, 0);
    q15.push_back({32'd1, 32'h0000_006F});
    send_word(32'h0000_006F, 0);
    chk("t1_done_during_wr", 64'(done15), 0);
    chk("t1_crst_during_wr", 64'(crst15), 0);
    step();
    chk("t1_done", 64'(done15), 1);
    chk("t1_core_rstn", 64'(crst15), 1);
    chk("t1_loaded", 64'(lw15), 2);
    chk("t1_q_empty", 64'(q15.size()), 0);

    // 2: empty image goes straight to run
    reset15();
    send_word(32'd0, 0);
    chk("t2_done", 64'(done15), 1);
    chk("t2_core_rstn", 64'(crst15), 1);
    fetch_raddr = 32'h0000_000C; #1;
    chk("t2_addr", 64'(addr15), 3);
    chk("t2_addr1", 64'(addr1_15), 4);
    send_word(32'h1234_5678, 0);
    chk("t2_loaded", 64'(lw15), 0);
    fetch_raddr = 32'h0;
    rstn15 = 1'b0;

    // 3: oversize header on the small instance
    reset4();
    send_word(32'd17, 0);
    chk("t3_err", 64'(err4), 1);
    chk("t3_core_rstn", 64'(crst4), 0);
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 1);
    chk("t3_err_held", 64'(err4), 1);
    chk("t3_done", 64'(done4), 0);
    chk("t3_loaded", 64'(lw4), 0);

    // 4: image that fills the small memory exactly
    reset4();
    send_word(32'd16, 0);
    for (int i = 0; i < 16; i++) begin
      q4.push_back({32'(i), 32'hA5000000 | 32'(i * 3)});
      send_word(32'hA5000000 | 32'(i * 3), 0);
    end
    step();
    chk("t4_loaded", 64'(lw4), 16);
    chk("t4_done", 64'(done4), 1);
    chk("t4_core_rstn", 64'(crst4), 1);
    chk("t4_q_empty", 64'(q4.size()), 0);
    fetch_raddr = 32'h0000_003C; #1;
    chk("t4_addr", 64'(addr4), 15);
    chk("t4_addr1_wrap", 64'(addr1_4), 0);
    fetch_raddr = 32'h0;
    rstn4 = 1'b0;

    // 5: same image back-to-back, then with random idle gaps
    for (int i = 0; i < 5; i++) words5[i] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      reset15();
      send_word(32'd5, 0);
      for (int i = 0; i < 5; i++) begin
        q15.push_back({32'(i), words5[i]});
        for (int k = 0; k < 4; k++)
          send_byte(words5[i][8*k +: 8], pass == 0 ? 0 : int'($urandom_range(0, 7)));
      end
      repeat (2) step();
      chk("t5_loaded", 64'(lw15), 5);
      chk("t5_done", 64'(done15), 1);
      chk("t5_q_empty", 64'(q15.size()), 0);
    end

    // 6: reset mid-load, then a fresh one-word image
    reset15();
    send_word(32'd4, 0);
    q15.push_back({32'd0, 32'h0403_0201});
    for (int k = 1; k <= 6; k++) send_byte(8'(k), 0);
    chk("t6_partial_loaded", 64'(lw15), 1);
    reset15();
    send_word(32'd1, 0);
    q15.push_back({32'd0, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 0);
    step();
    chk("t6_done", 64'(done15), 1);
    chk("t6_loaded", 64'(lw15), 1);
    chk("t6_q_empty", 64'(q15.size()), 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
